// File: rtl/flash_sample_reader.sv
// Fetches 32-bit words from an Avalon-MM flash port and hands out one 16-bit
// audio sample per tick. Each word holds two samples, so a fetch covers two ticks.
module flash_sample_reader #(
  parameter int unsigned       ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic              outclk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [15:0]       sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

  state_t            state;
  logic [31:0]       word_q;
  logic              half_pend;
  logic              pend_hi;
  logic              restart_pend;
  logic              tick_go;
  logic [15:0]       pend_half;
  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] start_addr;

  assign tick_go    = sample_tick && play;
  assign pend_half  = pend_hi ? word_q[31:16] : word_q[15:0];
  assign start_addr = dir ? MAX_ADDR : '0;

  always_comb begin
    step_addr = mem_addr;
    if (dir) begin
      step_addr = (mem_addr == '0) ? MAX_ADDR : mem_addr - ADDR_W'(1);
    end else begin
      step_addr = (mem_addr == MAX_ADDR) ? '0 : mem_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge outclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      word_q       <= '0;
      half_pend    <= 1'b0;
      pend_hi      <= 1'b0;
      restart_pend <= 1'b0;
      mem_read     <= 1'b0;
      mem_addr     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (restart) begin
            mem_addr  <= start_addr;
            half_pend <= 1'b0;
          end else if (tick_go) begin
            if (half_pend) begin
              sample       <= pend_half;
              sample_valid <= 1'b1;
              half_pend    <= 1'b0;
              mem_addr     <= step_addr;
            end else begin
              state    <= REQ;
              mem_read <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_readdatavalid) begin
            word_q <= mem_readdata;
            state  <= EMIT;
          end
        end
        EMIT: begin
          state        <= IDLE;
          busy         <= 1'b0;
          restart_pend <= 1'b0;
          // A restart seen during the fetch (or right now) discards the word
          // and repositions, so IDLE always starts from a settled address.
          if (restart_pend || restart) begin
            mem_addr  <= start_addr;
            half_pend <= 1'b0;
          end else begin
            sample       <= dir ? word_q[31:16] : word_q[15:0];
            sample_valid <= 1'b1;
            half_pend    <= 1'b1;
            pend_hi      <= ~dir;
          end
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && tick_go) begin
        overrun <= 1'b1;
      end
      if ((state == REQ || state == WAIT) && restart) begin
        restart_pend <= 1'b1;
      end
    end
  end

endmodule
